// File: rtl/fp_fmt_pkg.sv
// Shared definitions for the 11-bit {exn, sign, exp[3:0], frac[3:0]} floating-point format
// used by the fsqrt / fsquare_seq operator pair.
package fp_fmt_pkg;

    localparam int WE   = 4;
    localparam int WF   = 4;
    localparam int BIAS = 7;
    localparam int W    = WE + WF + 3;

    localparam logic [1:0] EXN_ZERO = 2'b00;
    localparam logic [1:0] EXN_NORM = 2'b01;
    localparam logic [1:0] EXN_INF  = 2'b10;
    localparam logic [1:0] EXN_NAN  = 2'b11;

    localparam logic [W-1:0] POS_ZERO = 11'h000;
    localparam logic [W-1:0] POS_INF  = 11'h400;
    localparam logic [W-1:0] QNAN     = 11'h600;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fsq_state_t;

endpackage

// File: rtl/fsq_round_pack.sv
// Normalises the 10-bit mantissa square, rounds it to nearest-even and packs the result,
// saturating to +inf on exponent overflow and flushing to +0 on underflow.
module fsq_round_pack
    import fp_fmt_pkg::*;
(
    input  logic [2*(WF+1)-1:0] p,
    input  logic [WE-1:0]       exp,
    output logic [W-1:0]        r
);

    logic              e_adj;
    logic [WF-1:0]     frac_r;
    logic              g;
    logic              sticky;
    logic              rnd;
    logic [WF:0]       f_sum;
    logic signed [6:0] e_b;

    always_comb begin
        if (p[9]) begin
            frac_r = p[8:5];
            g      = p[4];
            sticky = |p[3:0];
            e_adj  = 1'b1;
        end else begin
            frac_r = p[7:4];
            g      = p[3];
            sticky = |p[2:0];
            e_adj  = 1'b0;
        end

        rnd   = g & (sticky | frac_r[0]);
        f_sum = {1'b0, frac_r} + {{WF{1'b0}}, rnd};

        // Squaring doubles the unbiased exponent: 2*(exp-B)+B = 2*exp-B.
        e_b = $signed({2'b00, exp, 1'b0}) - 7'(BIAS)
            + $signed({6'b0, e_adj}) + $signed({6'b0, f_sum[WF]});

        if (e_b > 7'sd15) begin
            r = POS_INF;
        end else if (e_b < 7'sd0) begin
            r = POS_ZERO;
        end else begin
            r = {EXN_NORM, 1'b0, e_b[WE-1:0], f_sum[WF-1:0]};
        end
    end

endmodule

// File: rtl/fsquare_seq.sv
// Sequential squarer R = X*X: a five-cycle shift-add mantissa multiplier followed by one
// round/pack cycle, with valid/ready handshakes on input and output.
module fsquare_seq
    import fp_fmt_pkg::*;
#(
    parameter int ID = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] R
);

    localparam int UNUSED_ID = ID;

    fsq_state_t          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2*(WF+1)-1:0] acc_q, acc_d;
    logic [WF:0]         mcand_q, mcand_d;
    logic [1:0]          exn_q, exn_d;
    logic [WE-1:0]       exp_q, exp_d;
    logic [W-1:0]        r_q, r_d;
    logic [W-1:0]        packed_r;

    // The result is always positive, so the operand sign is never consulted.
    logic unused_sign;
    assign unused_sign = X[8];

    fsq_round_pack u_round_pack (
        .p   (acc_q),
        .exp (exp_q),
        .r   (packed_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            exn_q   <= EXN_ZERO;
            exp_q   <= '0;
            r_q     <= POS_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            exn_q   <= exn_d;
            exp_q   <= exp_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        exn_d   = exn_q;
        exp_d   = exp_q;
        r_d     = r_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exn_d   = X[10:9];
                    exp_d   = X[7:4];
                    mcand_d = {1'b1, X[3:0]};
                    cnt_d   = '0;
                    acc_d   = '0;
                    // Specials still pass through the packing cycle, giving them a
                    // one-cycle latency that matches the normal path's final step.
                    state_d = (X[10:9] == EXN_NORM) ? MUL : NORM;
                end
            end
            MUL: begin
                if (mcand_q[cnt_q]) begin
                    acc_d = acc_q + ({{(WF+1){1'b0}}, mcand_q} << cnt_q);
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(WF)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                unique case (exn_q)
                    EXN_ZERO: r_d = POS_ZERO;
                    EXN_INF:  r_d = POS_INF;
                    EXN_NAN:  r_d = QNAN;
                    default:  r_d = packed_r;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign R         = r_q;

endmodule

// File: tb/tb_fsquare_seq.sv
// Directed self-checking bench for fsquare_seq: results, latency, backpressure,
// asynchronous reset and throughput.
module tb_fsquare_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] X;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] R;

    int n_cmp = 0;
    int n_bad = 0;

    fsquare_seq #(.ID(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: offers x, waits for out_valid, returns result and latency.
    task automatic run_op(input logic [10:0] x, output logic [10:0] r,
                          output int lat, output bit timeout);
        int w = 0;
        while (!in_ready && w < 30) begin
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b1;
        X        = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        r       = R;
        timeout = !out_valid;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        X         = 11'h000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (R !== 11'h000) begin
            n_bad++; $display("FAIL reset_R: got %h want 000", R);
        end
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        $display("test_reset: out_valid=%b in_ready=%b R=%h", out_valid, in_ready, R);
    endtask

    task automatic test_normal();
        logic [10:0] vx [12] = '{11'h270, 11'h278, 11'h378, 11'h27C, 11'h2C0, 11'h220,
                                 11'h2BF, 11'h273, 11'h277, 11'h240, 11'h2B0, 11'h230};
        logic [10:0] vr [12] = '{11'h270, 11'h282, 11'h282, 11'h288, 11'h400, 11'h000,
                                 11'h400, 11'h277, 11'h281, 11'h210, 11'h2F0, 11'h000};
        logic [10:0] r;
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_op(vx[i], r, lat, to);
            n_cmp++;
            if (to) begin
                n_bad++; $display("FAIL normal_timeout: X=%h got no out_valid want valid", vx[i]);
            end else if (r !== vr[i]) begin
                n_bad++; $display("FAIL normal_R: X=%h got %h want %h", vx[i], r, vr[i]);
            end
            n_cmp++;
            if (lat != 6) begin
                n_bad++; $display("FAIL normal_latency: X=%h got %0d want 6", vx[i], lat);
            end
            $display("test_normal: X=%h R=%h latency=%0d", vx[i], r, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        logic [10:0] vx [6] = '{11'h100, 11'h500, 11'h6A5, 11'h000, 11'h400, 11'h7FF};
        logic [10:0] vr [6] = '{11'h000, 11'h400, 11'h600, 11'h000, 11'h400, 11'h600};
        logic [10:0] r;
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(vx[i], r, lat, to);
            n_cmp++;
            if (to) begin
                n_bad++; $display("FAIL special_timeout: X=%h got no out_valid want valid", vx[i]);
            end else if (r !== vr[i]) begin
                n_bad++; $display("FAIL special_R: X=%h got %h want %h", vx[i], r, vr[i]);
            end
            n_cmp++;
            if (lat != 1) begin
                n_bad++; $display("FAIL special_latency: X=%h got %0d want 1", vx[i], lat);
            end
            $display("test_special: X=%h R=%h latency=%0d", vx[i], r, lat);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] r;
        int lat;
        bit to;
        int bad_cycles = 0;
        out_ready = 1'b0;
        run_op(11'h278, r, lat, to);
        n_cmp++;
        if (to || r !== 11'h282) begin
            n_bad++; $display("FAIL stall_R_first: got %h want 282", r);
        end
        in_valid = 1'b1;
        X        = 11'h100;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (R !== 11'h282 || in_ready !== 1'b0 || out_valid !== 1'b1) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++; $display("FAIL stall_hold: got %0d disturbed cycles (R=%h in_ready=%b) want 0",
                              bad_cycles, R, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0/1",
                              out_valid, in_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_no_accept: got out_valid=%b want 0", out_valid);
        end
        $display("test_backpressure: R=%h held, disturbed cycles=%0d", R, bad_cycles);
    endtask

    task automatic test_reset_mid_op();
        logic [10:0] r;
        int lat;
        bit to;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        X         = 11'h278;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rst_mul: got in_ready=%b out_valid=%b want 1/0",
                              in_ready, out_valid);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        // Reset while a result is being held in DONE.
        out_ready = 1'b0;
        run_op(11'h278, r, lat, to);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || R !== 11'h000) begin
            n_bad++; $display("FAIL rst_done: got out_valid=%b R=%h want 0/000", out_valid, R);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_op(11'h270, r, lat, to);
        n_cmp++;
        if (to || r !== 11'h270 || lat != 6) begin
            n_bad++; $display("FAIL rst_recover: got R=%h latency=%0d want 270/6", r, lat);
        end
        $display("test_reset_mid_op: recovered R=%h latency=%0d", r, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input logic [10:0] x, input int period);
        int seen [$];
        out_ready = 1'b1;
        X         = x;
        in_valid  = 1'b1;
        for (int c = 0; c < 40 && seen.size() < 3; c++) begin
            if (in_ready) seen.push_back(c);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (seen.size() < 3) begin
            n_bad++; $display("FAIL throughput_%h: got %0d accepts want 3", x, seen.size());
        end else if (seen[2] - seen[1] != period) begin
            n_bad++; $display("FAIL throughput_%h: got period %0d want %0d",
                              x, seen[2] - seen[1], period);
        end
        if (seen.size() >= 3)
            $display("test_back_to_back: X=%h period=%0d", x, seen[2] - seen[1]);
        for (int c = 0; c < 20 && !(in_ready && !out_valid); c++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back(11'h278, 8);
        test_back_to_back(11'h500, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
